microoperation_sequencer: RTL and testbench

Issue/writeback stage directly upstream of the arithmetic microoperation unit. It accepts 3-bit microoperation instructions over a valid/ready handshake and reads two operands from a 4-entry × 4-bit signed register file. It drives the ALU's select, carry and operand inputs, then captures the ALU's registered 5-bit result one cycle later. It writes the low 4 bits back to the register file and updates zero and overflow status flags.

---
 rtl/microop_pkg.sv | 22 ++
 rtl/microoperation_sequencer_if.sv | 21 ++
 rtl/microop_regfile.sv | 45 ++++
 rtl/microoperation_sequencer.sv | 116 +++++++++++
 tb/tb_microoperation_sequencer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/microop_pkg.sv
// Shared constants, op-code map and FSM state type for the microoperation
// issue/writeback stage.
package microop_pkg;
  localparam int WIDTH  = 4;
  localparam int REGS   = 4;
  localparam int ADDR_W = $clog2(REGS);

  localparam logic [2:0] OP_ADD     = 3'd0;
  localparam logic [2:0] OP_ADDC    = 3'd1;
  localparam logic [2:0] OP_ADD_NOT = 3'd2;
  localparam logic [2:0] OP_SUB     = 3'd3;
  localparam logic [2:0] OP_PASS    = 3'd4;
  localparam logic [2:0] OP_INC     = 3'd5;
  localparam logic [2:0] OP_DEC     = 3'd6;
  localparam logic [2:0] OP_PASS2   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WRITE = 2'd2
  } state_e;
endpackage

// File: rtl/microoperation_sequencer_if.sv
// Instruction issue handshake between an instruction source and the sequencer.
interface microoperation_sequencer_if;
  import microop_pkg::*;

  logic              instr_valid;
  logic              instr_ready;
  logic [2:0]        instr_op;
  logic [ADDR_W-1:0] instr_dst;
  logic [ADDR_W-1:0] instr_src_a;
  logic [ADDR_W-1:0] instr_src_b;

  modport master (
    output instr_valid, instr_op, instr_dst, instr_src_a, instr_src_b,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_op, instr_dst, instr_src_a, instr_src_b,
    output instr_ready
  );
endinterface

// File: rtl/microop_regfile.sv
// 4x4 signed register file: two operand read ports, a debug read port and a
// single write port shared between direct loads and ALU writeback.
module microop_regfile
  import microop_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        rd_a_addr,
  input  logic [ADDR_W-1:0]        rd_b_addr,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic signed [WIDTH-1:0]  rd_a_data,
  output logic signed [WIDTH-1:0]  rd_b_data,
  output logic signed [WIDTH-1:0]  dbg_data,
  input  logic                     load_en,
  input  logic [ADDR_W-1:0]        load_addr,
  input  logic signed [WIDTH-1:0]  load_value,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic signed [WIDTH-1:0]  wb_data
);
  logic signed [WIDTH-1:0] regs_q [REGS];
  logic signed [WIDTH-1:0] regs_d [REGS];

  assign rd_a_data = regs_q[rd_a_addr];
  assign rd_b_data = regs_q[rd_b_addr];
  assign dbg_data  = regs_q[dbg_addr];

  // Loads and writeback never overlap in time; writeback wins if they ever did.
  always_comb begin
    regs_d = regs_q;
    if (wb_en) begin
      regs_d[wb_addr] = wb_data;
    end else if (load_en) begin
      regs_d[load_addr] = load_value;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end
endmodule

// File: rtl/microoperation_sequencer.sv
// Issue/writeback stage: accepts an instruction, drives the registered ALU
// operands for one cycle, then writes the ALU result back and updates flags.
module microoperation_sequencer
  import microop_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  microoperation_sequencer_if.slave  instr,
  input  logic                       load_en,
  input  logic [ADDR_W-1:0]          load_addr,
  input  logic signed [WIDTH-1:0]    load_value,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic signed [WIDTH-1:0]    rd_data,
  output logic [1:0]                 alu_select,
  output logic                       alu_carry,
  output logic signed [WIDTH-1:0]    alu_a,
  output logic signed [WIDTH-1:0]    alu_b,
  input  logic signed [WIDTH:0]      alu_data,
  output logic                       done,
  output logic                       flag_zero,
  output logic                       flag_overflow
);
  state_e                  state_q, state_d;
  logic [2:0]              op_q, op_d;
  logic [ADDR_W-1:0]       dst_q, dst_d;
  logic signed [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic                    done_q, done_d;
  logic                    zero_q, zero_d;
  logic                    ovf_q, ovf_d;
  logic                    accept, wb_en, load_ok;
  logic signed [WIDTH-1:0] src_a_data, src_b_data;

  assign instr.instr_ready = (state_q == ST_IDLE) && !load_en;
  assign accept            = instr.instr_valid && instr.instr_ready;
  assign load_ok           = load_en && (state_q == ST_IDLE);

  microop_regfile u_regfile (
    .clock      (clock),
    .reset      (reset),
    .rd_a_addr  (instr.instr_src_a),
    .rd_b_addr  (instr.instr_src_b),
    .dbg_addr   (rd_addr),
    .rd_a_data  (src_a_data),
    .rd_b_data  (src_b_data),
    .dbg_data   (rd_data),
    .load_en    (load_ok),
    .load_addr  (load_addr),
    .load_value (load_value),
    .wb_en      (wb_en),
    .wb_addr    (dst_q),
    .wb_data    (alu_data[WIDTH-1:0])
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dst_d   = dst_q;
    a_d     = a_q;
    b_d     = b_q;
    done_d  = 1'b0;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    wb_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ISSUE;
          op_d    = instr.instr_op;
          dst_d   = instr.instr_dst;
          a_d     = src_a_data;
          b_d     = src_b_data;
        end
      end
      ST_ISSUE: state_d = ST_WRITE;
      ST_WRITE: begin
        // The ALU registered its result at the end of ISSUE; it is stable now.
        state_d = ST_IDLE;
        wb_en   = 1'b1;
        done_d  = 1'b1;
        zero_d  = (alu_data[WIDTH-1:0] == '0);
        ovf_d   = (alu_data[WIDTH] != alu_data[WIDTH-1]);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      dst_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      a_q     <= a_d;
      b_q     <= b_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

  assign alu_select    = op_q[2:1];
  assign alu_carry     = op_q[0];
  assign alu_a         = a_q;
  assign alu_b         = b_q;
  assign done          = done_q;
  assign flag_zero     = zero_q;
  assign flag_overflow = ovf_q;
endmodule

// File: tb/tb_microoperation_sequencer.sv
// Bench for microoperation_sequencer: registered ALU model, register-file
// reference model, directed cases then randomized instruction streams.
module tb_microoperation_sequencer;
  import microop_pkg::*;

  logic       clock;
  logic       reset;
  logic       load_en;
  logic [1:0] load_addr;
  logic [3:0] load_value;
  logic [1:0] rd_addr;
  logic [3:0] rd_data;
  logic [1:0] alu_select;
  logic       alu_carry;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [4:0] alu_data;
  logic       done;
  logic       flag_zero;
  logic       flag_overflow;

  int checks;
  int errors;

  logic [3:0] mreg [4];
  logic       m_zero;
  logic       m_ovf;
  logic [1:0] prev_dst;

  microoperation_sequencer_if instr_if ();

  microoperation_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .instr         (instr_if),
    .load_en       (load_en),
    .load_addr     (load_addr),
    .load_value    (load_value),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .alu_select    (alu_select),
    .alu_carry     (alu_carry),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_data      (alu_data),
    .done          (done),
    .flag_zero     (flag_zero),
    .flag_overflow (flag_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Arithmetic meaning of each op code on signed integer operands.
  function automatic int ref_alu(input logic [2:0] op, input int a, input int b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a + b + 1;
      3'd2:    return a + (-b - 1);
      3'd3:    return a - b;
      3'd5:    return a + 1;
      3'd6:    return a - 1;
      default: return a;
    endcase
  endfunction

  // Downstream ALU: registers its 5-bit result every rising edge.
  always @(posedge clock)
    alu_data <= 5'(ref_alu({alu_select, alu_carry}, int'($signed(alu_a)), int'($signed(alu_b))));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load_reg(input logic [1:0] addr, input logic [3:0] val);
    load_en    = 1'b1;
    load_addr  = addr;
    load_value = val;
    #1;
    check_eq("ready_during_load", instr_if.instr_ready, 0);
    step();
    load_en    = 1'b0;
    mreg[addr] = val;
    rd_addr    = addr;
    #1;
    check_eq("load_readback", rd_data, mreg[addr]);
  endtask

  task automatic do_instr(input logic [2:0] op, input logic [1:0] dst,
                          input logic [1:0] sa, input logic [1:0] sb, input bit junk);
    int          r;
    logic [31:0] rv;
    logic [3:0]  ea, eb;
    ea = mreg[sa];
    eb = mreg[sb];
    r  = ref_alu(op, int'($signed(ea)), int'($signed(eb)));
    rv = r;

    instr_if.instr_valid = 1'b1;
    instr_if.instr_op    = op;
    instr_if.instr_dst   = dst;
    instr_if.instr_src_a = sa;
    instr_if.instr_src_b = sb;
    #1;
    check_eq("ready_idle", instr_if.instr_ready, 1);
    step();

    // ISSUE cycle; optionally present another instruction and a stray load.
    if (junk) begin
      instr_if.instr_op    = 3'($urandom);
      instr_if.instr_dst   = 2'($urandom);
      load_en              = 1'b1;
      load_addr            = dst;
      load_value           = 4'($urandom);
    end else begin
      instr_if.instr_valid = 1'b0;
    end
    #1;
    check_eq("issue_alu_a", alu_a, ea);
    check_eq("issue_alu_b", alu_b, eb);
    check_eq("issue_select", alu_select, op[2:1]);
    check_eq("issue_carry", alu_carry, op[0]);
    check_eq("issue_ready", instr_if.instr_ready, 0);
    check_eq("issue_done", done, 0);
    step();

    check_eq("write_ready", instr_if.instr_ready, 0);
    check_eq("write_done", done, 0);
    check_eq("write_alu_a_hold", alu_a, ea);
    step();

    instr_if.instr_valid = 1'b0;
    load_en   = 1'b0;
    mreg[dst] = rv[3:0];
    m_zero    = (rv[3:0] == 4'd0);
    m_ovf     = (r < -8) || (r > 7);
    rd_addr   = dst;
    #1;
    check_eq("wb_done", done, 1);
    check_eq("wb_alu_data", alu_data, rv[4:0]);
    check_eq("wb_reg", rd_data, mreg[dst]);
    check_eq("wb_zero", flag_zero, m_zero);
    check_eq("wb_ovf", flag_overflow, m_ovf);
    check_eq("wb_ready", instr_if.instr_ready, 1);
    prev_dst = dst;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    load_en = 1'b0;
    load_addr = '0;
    load_value = '0;
    rd_addr = '0;
    instr_if.instr_valid = 1'b0;
    instr_if.instr_op    = '0;
    instr_if.instr_dst   = '0;
    instr_if.instr_src_a = '0;
    instr_if.instr_src_b = '0;
    for (int i = 0; i < 4; i++) mreg[i] = '0;
    m_zero = 1'b0;
    m_ovf  = 1'b0;
    prev_dst = '0;

    #1;
    check_eq("rst_ready", instr_if.instr_ready, 1);
    check_eq("rst_done", done, 0);
    check_eq("rst_zero", flag_zero, 0);
    check_eq("rst_ovf", flag_overflow, 0);
    check_eq("rst_alu_a", alu_a, 0);
    check_eq("rst_alu_b", alu_b, 0);
    check_eq("rst_sel_carry", {alu_select, alu_carry}, 0);
    check_eq("rst_reg0", rd_data, 0);
    repeat (2) step();
    reset = 1'b1;
    step();

    // Directed cases.
    load_reg(2'd1, 4'd3);
    load_reg(2'd2, 4'd2);
    do_instr(3'd0, 2'd0, 2'd1, 2'd2, 1'b0);
    load_reg(2'd3, 4'd7);
    do_instr(3'd5, 2'd3, 2'd3, 2'd0, 1'b0);
    check_eq("inc7_ovf", flag_overflow, 1);
    load_reg(2'd0, 4'd0);
    do_instr(3'd6, 2'd0, 2'd0, 2'd0, 1'b0);
    check_eq("dec0_data", alu_data, 5'b11111);
    load_reg(2'd1, 4'd3);
    load_reg(2'd2, 4'd3);
    do_instr(3'd3, 2'd1, 2'd1, 2'd2, 1'b1);
    check_eq("sub_zero", flag_zero, 1);
    do_instr(3'd2, 2'd2, 2'd3, 2'd1, 1'b1);

    // Reset asserted during WRITE: in-flight instruction discarded.
    load_reg(2'd1, 4'd4);
    load_reg(2'd2, 4'd1);
    instr_if.instr_valid = 1'b1;
    instr_if.instr_op    = 3'd0;
    instr_if.instr_dst   = 2'd0;
    instr_if.instr_src_a = 2'd1;
    instr_if.instr_src_b = 2'd2;
    step();
    instr_if.instr_valid = 1'b0;
    step();
    #2;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) mreg[i] = '0;
    rd_addr = 2'd0;
    #1;
    check_eq("midrst_ready", instr_if.instr_ready, 1);
    check_eq("midrst_done", done, 0);
    check_eq("midrst_alu_a", alu_a, 0);
    check_eq("midrst_reg0", rd_data, 0);
    step();
    reset = 1'b1;
    step();
    check_eq("postrst_done", done, 0);
    check_eq("postrst_ready", instr_if.instr_ready, 1);
    check_eq("postrst_reg0", rd_data, 0);
    check_eq("postrst_zero", flag_zero, 0);
    check_eq("postrst_ovf", flag_overflow, 0);

    // Randomized stream, often dependent on the previous destination.
    for (int n = 0; n < 60; n++) begin
      logic [1:0] sa;
      if ($urandom_range(0, 2) == 0) load_reg(2'($urandom), 4'($urandom));
      sa = ($urandom_range(0, 1) == 1) ? prev_dst : 2'($urandom);
      do_instr(3'($urandom), 2'($urandom), sa, 2'($urandom), 1'($urandom));
    end

    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      check_eq("final_reg", rd_data, mreg[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
